alu_serial: RTL and testbench
=============================

// Module: alu_serial
// PURPOSE
//  Bit-serial N-bit ALU sequencer, the control/datapath stage that feeds alu1bit.
//  Latches two N-bit operands and an opcode, then steps one alu1bit instance LSB-first, one bit per clock.
//  Carry is registered between bits. The result is assembled in a shift register.
//  Sits between the operand source (register file / testbench) and the result consumer.
// PARAMETERS
//  N  8  operand/result width in bits (N >= 2); bit counter width is $clog2(N)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  operands/op presented
//  in_ready   out  1  block can accept a new operation
//  a_in       in   N  operand A
//  b_in       in   N  operand B
//  op_in      in   2  00 NOR, 01 XOR, 10 ADD, 11 SUB (A-B)
//  out_valid  out  1  one-cycle pulse: result/cout/zero valid
//  result     out  N  operation result, held until next accept
//  cout       out  1  final carry (ADD/SUB), 0 for NOR/XOR
//  zero       out  1  result == 0
// BEHAVIOUR
//  Clock and reset
//  - One clock, clk. rst is synchronous and active-high.
//  - On rst: state=IDLE, in_ready=1, out_valid=0, result=0, cout=0, zero=0; counter, carry and operand regs cleared.
//  - rst wins over every other event, including mid-RUN. A partial result is discarded, not reported.
//  FSM
//  - States: IDLE, RUN, DONE.
//  - IDLE: in_ready=1. If in_valid, latch a_in/b_in/op_in into shift regs, bit_cnt=0, carry=op_in[0], go to RUN.
//  - RUN: in_ready=0. Each cycle drive alu1bit with a=A[0], b=B[0], cin=carry, op=op_reg.
//    - Shift the s output into the MSB of res_sh (shift right). Shift A and B right. carry<=alu cout.
//    - When bit_cnt==N-1, go to DONE. Otherwise bit_cnt++.
//  - DONE: out_valid=1 for exactly this cycle; result<=res_sh; cout<=carry if op_reg[1] else 0; zero<=(res_sh==0).
//    - in_ready=1 in DONE. If in_valid, accept as in IDLE and go to RUN (back-to-back issue). Otherwise go to IDLE.
//  - Outputs are registered. result/cout/zero update at the DONE edge and are visible while out_valid=1.
//  Arithmetic
//  - SUB is A + ~B + 1: cin of bit 0 = op[0]=1, and alu1bit inverts B internally via a_ns.
//  - SUB cout=1 means no borrow.
//  - Arithmetic is modulo 2^N. The carry out of the MSB goes only to cout.
//  - For NOR/XOR the carry chain still runs but is ignored.
//  Latency and handshake
//  - Accept edge k. Bits are processed on cycles k+1..k+N. out_valid is high on cycle k+N+1.
//  - Throughput: one op per N+1 cycles.
//  - in_valid while in RUN is ignored (no queueing). The source must hold the request until in_ready.
//  - No output backpressure: a consumer that misses the out_valid pulse still reads the held result.
//  - Before the first op, result is 0 and zero=0.
// TESTING (N=8)
//  1. ADD A=0x3C, B=0x05 -> out_valid exactly 9 cycles after accept; result=0x41, cout=0, zero=0.
//  2. ADD A=0xFF, B=0x01 -> result=0x00, cout=1, zero=1.
//  3. SUB A=0x05, B=0x06 -> result=0xFF, cout=0 (borrow); then SUB A=0x06, B=0x05 -> result=0x01, cout=1.
//  4. NOR A=0xF0, B=0x0F -> result=0x00, zero=1, cout=0; XOR A=0xAA, B=0xFF -> result=0x55, cout=0.
//  5. Hold in_valid high with two ops, the second presented during RUN -> second ignored until DONE.
//     - Second accepted in the DONE cycle; out_valid pulses 9 cycles apart, each result correct.
//  6. rst asserted on the 4th RUN cycle of ADD 0x0F+0x01 -> next cycle state=IDLE, in_ready=1.
//     - result=0, out_valid never pulses for the aborted op; a fresh op afterwards computes correctly.

Source files
------------

// File: rtl/alu_serial.sv
// Bit-serial N-bit ALU sequencer: latches operands and opcode, then steps one
// alu1bit cell LSB-first, one bit per clock, with the carry registered between bits.

module alu1bit (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       s,
    output logic       cout
);

    logic a_ns;

    // B is inverted for SUB so that A - B = A + ~B + 1 (cin supplies the +1)
    assign a_ns = b ^ op[0];

    always_comb begin
        s    = 1'b0;
        cout = (a & a_ns) | (a & cin) | (a_ns & cin);
        case (op)
            2'b00:   s = ~(a | b);
            2'b01:   s = a ^ b;
            default: s = a ^ a_ns ^ cin;
        endcase
    end

endmodule

module alu_serial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [1:0]   op_in,
    output logic         out_valid,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         zero
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  res_sh;
    logic [N-1:0]  res_next;
    logic [1:0]    op_reg;
    logic [CW-1:0] bit_cnt;
    logic          carry;

    logic          alu_s;
    logic          alu_cout;
    logic          accept;
    logic          last_bit;

    alu1bit u_alu (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .op   (op_reg),
        .s    (alu_s),
        .cout (alu_cout)
    );

    assign in_ready = (state != RUN);
    assign accept   = in_ready & in_valid;
    assign last_bit = (state == RUN) && (bit_cnt == CW'(N - 1));
    assign res_next = {alu_s, res_sh[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            op_reg    <= '0;
            bit_cnt   <= '0;
            carry     <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= last_bit;
            if (accept) begin
                a_sh    <= a_in;
                b_sh    <= b_in;
                op_reg  <= op_in;
                res_sh  <= '0;
                bit_cnt <= '0;
                carry   <= op_in[0];
            end else if (state == RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res_sh <= res_next;
                carry  <= alu_cout;
                if (!last_bit) begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
            // Outputs load from the final bit directly so they are already
            // valid during the DONE cycle alongside out_valid.
            if (last_bit) begin
                result <= res_next;
                cout   <= op_reg[1] & alu_cout;
                zero   <= (res_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial (N=8): directed vector table, randomized
// ops against an arithmetic reference model, back-to-back issue and mid-run reset.

module tb_alu_serial;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [1:0]   op_in;
    logic         out_valid;
    logic [N-1:0] result;
    logic         cout;
    logic         zero;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    alu_serial #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .op_in     (op_in),
        .out_valid (out_valid),
        .result    (result),
        .cout      (cout),
        .zero      (zero)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp_res;
        logic       exp_cout;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Reference: plain integer arithmetic on the opcode meanings.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         output logic [7:0] res, output logic c);
        int unsigned ia, ib;
        ia = a;
        ib = b;
        c  = 1'b0;
        case (op)
            2'b00: res = 8'(255 - (ia | ib));
            2'b01: res = 8'(ia ^ ib);
            2'b10: begin res = 8'((ia + ib) % 256); c = (ia + ib) > 255; end
            default: begin res = 8'((ia + 256 - ib) % 256); c = (ia >= ib); end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int unsigned n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) chk({name, " ready timeout"}, 0, 1);
    endtask

    // Issue one op, check latency (out_valid on the 9th cycle after accept),
    // the outputs, and that the pulse lasts one cycle with the result held.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [7:0] er, input logic ec,
                          input logic ez);
        int unsigned cyc = 0;
        wait_ready(name);
        a_in = a; b_in = b; op_in = op; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({name, " latency"}, cyc, 9);
        chk({name, " result"}, result, er);
        chk({name, " cout"}, cout, ec);
        chk({name, " zero"}, zero, ez);
        tick();
        chk({name, " pulse"}, out_valid, 0);
        chk({name, " held"}, result, er);
    endtask

    initial begin
        logic [7:0] ea, eb, er, er2;
        logic [1:0] eo;
        logic       ec, ec2;
        int unsigned pulses;
        int unsigned first_at, second_at;

        vecs[0] = '{8'h3C, 8'h05, 2'b10, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 2'b10, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'h05, 8'h06, 2'b11, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h06, 8'h05, 2'b11, 8'h01, 1'b1, 1'b0};
        vecs[4] = '{8'hF0, 8'h0F, 2'b00, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{8'hAA, 8'hFF, 2'b01, 8'h55, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 2'b11, 8'h00, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; op_in = '0;
        tick(); tick();
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset cout", cout, 0);
        chk("reset zero", zero, 0);
        rst = 1'b0;
        tick();
        chk("idle zero before first op", zero, 0);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                   vecs[i].exp_res, vecs[i].exp_cout, vecs[i].exp_zero);

        for (int i = 0; i < 30; i++) begin
            ea = 8'($urandom);
            eb = 8'($urandom);
            eo = 2'($urandom_range(3));
            model(ea, eb, eo, er, ec);
            run_op($sformatf("rand%0d", i), ea, eb, eo, er, ec, er == 8'h00);
            if ($urandom_range(1) == 1) tick();
        end

        // Back-to-back: second op presented during RUN must wait for DONE.
        wait_ready("b2b");
        model(8'h12, 8'h34, 2'b10, er, ec);
        model(8'h50, 8'h51, 2'b11, er2, ec2);
        a_in = 8'h12; b_in = 8'h34; op_in = 2'b10; in_valid = 1'b1;
        tick();
        a_in = 8'h50; b_in = 8'h51; op_in = 2'b11;
        pulses = 0; first_at = 0; second_at = 0;
        for (int c = 1; c <= 24; c++) begin
            if (c >= 1 && c <= 8) chk($sformatf("b2b busy c%0d", c), in_ready, 0);
            if (out_valid) begin
                pulses++;
                if (pulses == 1) begin
                    first_at = c;
                    chk("b2b first result", result, er);
                    chk("b2b first cout", cout, ec);
                    chk("b2b ready in done", in_ready, 1);
                end else if (pulses == 2) begin
                    second_at = c;
                    chk("b2b second result", result, er2);
                    chk("b2b second cout", cout, ec2);
                end
            end
            tick();
            if (pulses == 1 && first_at == c) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("b2b pulse count", pulses, 2);
        chk("b2b first latency", first_at, 9);
        chk("b2b spacing", second_at - first_at, 9);

        // Reset on the 4th RUN cycle aborts the op.
        wait_ready("rst");
        a_in = 8'h0F; b_in = 8'h01; op_in = 2'b10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort in_ready", in_ready, 1);
        chk("abort result", result, 0);
        chk("abort out_valid", out_valid, 0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) pulses++;
            tick();
        end
        chk("abort no pulse", pulses, 0);
        run_op("after abort", 8'h0F, 8'h01, 2'b10, 8'h10, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
